dsp_rst_seq: RTL and testbench
==============================

// Module: dsp_rst_seq
// PURPOSE
//  N-channel C6678 reset sequencer for the board CPLD; replaces the single-DSP fixed-delay logic.
//  Sequences RESETn (soft), PORn, RESETFULLn per DSP with runtime-independent parametrised phase delays.
//  Monitors each DSP's RESETSTATn and reports done/fail.
//  Accepts a masked re-sequence request so one DSP can be reset without disturbing the others.
// PARAMETERS
//  N_DSP    2        number of DSP channels (1..8)
//  CNT_W    20       phase counter width; every T_* must be < 2**CNT_W
//  T_SOFT   16'hC350 cycles all resets held before soft_n release (2 ms @ 25 MHz)
//  T_POR    20'h61A8 cycles from soft_n release to por_n release (1 ms)
//  T_FULL   20'h30D4 cycles from por_n release to full_n release (0.5 ms)
//  T_STRAP  16'd250  cycles strap_oe stays high after full_n release (boot-mode hold)
//  T_STAT   20'h30D4 cycles allowed for RESETSTATn to go high after full_n release
//  MAX_RETRY 2       watchdog retries per channel (DSP_RST_WDOG_EN only)
// PORTS
//  clk_sys        in   1      25 MHz system clock (BUFG output)
//  hard_rst_n     in   1      synchronous active-low reset
//  dsp_rstn_state in   N_DSP  RESETSTATn from each DSP, asynchronous
//  seq_req        in   1      one-cycle request to re-sequence channels in seq_mask
//  seq_mask       in   N_DSP  channels to re-sequence, sampled with seq_req
//  seq_ack        out  1      one-cycle pulse: request accepted
//  rst_soft_n     out  N_DSP  RESETn per DSP
//  rst_por_n      out  N_DSP  PORn per DSP
//  rst_full_n     out  N_DSP  RESETFULLn per DSP
//  strap_oe       out  N_DSP  boot-strap/endian pin drive enable per DSP
//  busy           out  1      sequence in progress
//  done           out  1      all channels in RUN with RESETSTATn high
//  fail_vec       out  N_DSP  sticky: channel timed out on T_STAT
//  lost_vec       out  N_DSP  sticky: RESETSTATn fell while channel in RUN
// BEHAVIOUR
//  Reset (hard_rst_n=0): all rst_*_n=0, strap_oe=all 1, busy=1, done=0, seq_ack=0, fail/lost=0,
//   active mask=all 1, FSM=HOLD, cnt=0. Reset mid-sequence aborts immediately to these values.
//  dsp_rstn_state passes a 2-flop synchroniser per bit; FSM uses synced value (2-cycle latency).
//  One shared FSM + counter; cnt clears on every state entry; state advances when cnt==T_x-1.
//  Only channels in the active mask are driven by the FSM; other channels hold their outputs.
//  HOLD  : masked soft/por/full=0, strap_oe=1; -> SOFT after T_SOFT cycles.
//  SOFT  : soft_n=1; -> POR after T_POR.  POR: por_n=1; -> FULL after T_FULL.
//  FULL  : full_n=1; strap_oe falls T_STRAP cycles after entry (if T_STRAP>=T_STAT, at RUN/FAIL entry).
//          -> RUN when all masked synced states=1; -> FAIL at cnt==T_STAT-1 if any low.
//          Both conditions in same cycle: RUN wins.
//  RUN   : busy=0, done=1 iff every channel's synced state=1; falling state sets lost_vec bit.
//  FAIL  : busy=0, done=0, fail_vec |= masked channels still low; resets stay released.
//  Cycle 0 = first edge with hard_rst_n=1: soft_n rises at T_SOFT, por_n at T_SOFT+T_POR,
//   full_n at T_SOFT+T_POR+T_FULL.
//  seq_req accepted only in RUN/FAIL with seq_mask!=0: seq_ack next cycle, mask<=seq_mask,
//   fail/lost bits of those channels cleared, FSM->HOLD. Otherwise ignored, no ack.
//  Counter never wraps: it saturates; equality compare only.
// CONFIGURATION
//  DSP_RST_WDOG_EN defined: on FAIL entry or lost_vec rise in RUN, FSM auto re-sequences the
//   affected channels (mask=those bits) if their retry count < MAX_RETRY; count per channel,
//   cleared by hard_rst_n or accepted seq_req; at limit FSM stays in FAIL / RUN with lost_vec set.
//  Not defined: no automatic action; FAIL/lost are reported only; retry counters absent.
// STRUCTURE
//  Package dsp_rst_pkg: state enum (HOLD,SOFT,POR,FULL,RUN,FAIL), default T_* constants @ 25 MHz.
//  Sub-module dsp_rststat_sync: per-channel 2-flop synchroniser + falling-edge detect.
// TESTING (bench params: N_DSP=2, T_SOFT=10, T_POR=5, T_FULL=4, T_STRAP=3, T_STAT=20)
//  Power-up, state tied 1 -> soft_n=11 at cycle 10, por_n 15, full_n 19, strap_oe=00 at 22, done at 21.
//  state[1] held 0 -> FAIL at cycle 38, fail_vec=10, done=0, resets stay 1.
//  In RUN, seq_req mask=01 -> ack next cycle; ch0 resets drop to 0, ch1 outputs unchanged; done re-asserts.
//  seq_req during SOFT -> no ack, sequence timing unchanged; hard_rst_n=0 mid-POR -> all outputs reset next edge.
//  state[0] drops in RUN -> lost_vec=01, done=0; with DSP_RST_WDOG_EN: ch0 re-sequenced twice, then stays.

Source files
------------

// File: rtl/dsp_rst_pkg.sv
// Shared types and default phase lengths for the DSP reset sequencer.
// Default delays assume the 25 MHz board clock.
package dsp_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_SOFT,
        ST_POR,
        ST_FULL,
        ST_RUN,
        ST_FAIL
    } seq_state_t;

    localparam int unsigned DEF_N_DSP     = 2;
    localparam int unsigned DEF_CNT_W     = 20;
    localparam int unsigned DEF_T_SOFT    = 32'hC350;
    localparam int unsigned DEF_T_POR     = 32'h61A8;
    localparam int unsigned DEF_T_FULL    = 32'h30D4;
    localparam int unsigned DEF_T_STRAP   = 250;
    localparam int unsigned DEF_T_STAT    = 32'h30D4;
    localparam int unsigned DEF_MAX_RETRY = 2;

endpackage

// File: rtl/dsp_rststat_sync.sv
// Two-flop synchroniser for one DSP RESETSTATn pin plus falling-edge detect.
// synced lags the pin by 2 cycles; fall is a 1-cycle pulse aligned with synced going low.
module dsp_rststat_sync (
    input  logic clk_sys,
    input  logic hard_rst_n,
    input  logic async_in,
    output logic synced,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_sys) begin
        if (!hard_rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign synced = sync_q;
    assign fall   = prev_q & ~sync_q;

endmodule

// File: rtl/dsp_rst_seq.sv
// N-channel C6678 reset sequencer: HOLD->SOFT->POR->FULL->RUN/FAIL with masked re-sequencing.
// Pin outputs register one cycle after state; DSP_RST_WDOG_EN adds bounded automatic retries.
module dsp_rst_seq
    import dsp_rst_pkg::*;
#(
    parameter int unsigned N_DSP     = DEF_N_DSP,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned T_SOFT    = DEF_T_SOFT,
    parameter int unsigned T_POR     = DEF_T_POR,
    parameter int unsigned T_FULL    = DEF_T_FULL,
    parameter int unsigned T_STRAP   = DEF_T_STRAP,
    parameter int unsigned T_STAT    = DEF_T_STAT,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic             clk_sys,
    input  logic             hard_rst_n,
    input  logic [N_DSP-1:0] dsp_rstn_state,
    input  logic             seq_req,
    input  logic [N_DSP-1:0] seq_mask,
    output logic             seq_ack,
    output logic [N_DSP-1:0] rst_soft_n,
    output logic [N_DSP-1:0] rst_por_n,
    output logic [N_DSP-1:0] rst_full_n,
    output logic [N_DSP-1:0] strap_oe,
    output logic             busy,
    output logic             done,
    output logic [N_DSP-1:0] fail_vec,
    output logic [N_DSP-1:0] lost_vec
);

    if (N_DSP < 1 || N_DSP > 8 || MAX_RETRY > 255 ||
        T_SOFT < 1 || T_POR < 1 || T_FULL < 1 || T_STAT < 1 ||
        T_SOFT >= 2**CNT_W || T_POR >= 2**CNT_W || T_FULL >= 2**CNT_W ||
        T_STRAP >= 2**CNT_W || T_STAT >= 2**CNT_W) begin : g_bad_cfg
        $error("dsp_rst_seq: invalid parameter set");
    end

    localparam logic [CNT_W-1:0] SOFT_END  = CNT_W'(T_SOFT - 1);
    localparam logic [CNT_W-1:0] POR_END   = CNT_W'(T_POR - 1);
    localparam logic [CNT_W-1:0] FULL_END  = CNT_W'(T_FULL - 1);
    localparam logic [CNT_W-1:0] STAT_END  = CNT_W'(T_STAT - 1);
    localparam logic [CNT_W-1:0] STRAP_LEN = CNT_W'(T_STRAP);
    localparam bit               STRAP_AT_END = (T_STRAP >= T_STAT);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] strap_cnt;
    logic [CNT_W-1:0] strap_inc;
    logic [N_DSP-1:0] mask;
    logic [N_DSP-1:0] stat;
    logic [N_DSP-1:0] stat_fall;
    logic [N_DSP-1:0] auto_mask;
    logic [N_DSP-1:0] reseq_mask;
    logic [N_DSP-1:0] clr_mask;
    logic [N_DSP-1:0] fail_set;
    logic [N_DSP-1:0] lost_set;
    logic             accept;
    logic             reseq;
    logic             masked_up;
    logic             full_released;
    logic             drive_soft;
    logic             drive_por;
    logic             drive_full;
    logic             drive_strap;

    for (genvar g = 0; g < N_DSP; g++) begin : g_sync
        dsp_rststat_sync u_sync (
            .clk_sys    (clk_sys),
            .hard_rst_n (hard_rst_n),
            .async_in   (dsp_rstn_state[g]),
            .synced     (stat[g]),
            .fall       (stat_fall[g])
        );
    end

`ifdef DSP_RST_WDOG_EN
    localparam int unsigned RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTY_W-1:0] retry [N_DSP];

    always_comb begin
        auto_mask = '0;
        for (int i = 0; i < N_DSP; i++) begin
            if (retry[i] < RTY_W'(MAX_RETRY)) begin
                if (state == ST_FAIL)     auto_mask[i] = fail_vec[i];
                else if (state == ST_RUN) auto_mask[i] = lost_vec[i];
            end
        end
    end

    // An operator request resets the retry budget of the channels it names.
    always_ff @(posedge clk_sys) begin
        if (!hard_rst_n) begin
            for (int i = 0; i < N_DSP; i++) retry[i] <= '0;
        end else begin
            for (int i = 0; i < N_DSP; i++) begin
                if (accept && seq_mask[i])       retry[i] <= '0;
                else if (!accept && auto_mask[i]) retry[i] <= retry[i] + RTY_W'(1);
            end
        end
    end
`else
    assign auto_mask = '0;
`endif

    always_comb begin
        cnt_inc       = (&cnt) ? cnt : cnt + CNT_W'(1);
        strap_inc     = (&strap_cnt) ? strap_cnt : strap_cnt + CNT_W'(1);
        accept        = seq_req && (state == ST_RUN || state == ST_FAIL) && (|seq_mask);
        reseq         = accept || (|auto_mask);
        reseq_mask    = accept ? seq_mask : auto_mask;
        clr_mask      = reseq ? reseq_mask : '0;
        masked_up     = &(stat | ~mask);
        // RESETSTATn may be stale high; only trust it once RESETFULLn is actually out.
        full_released = &(rst_full_n | ~mask);

        state_nxt = state;
        case (state)
            ST_HOLD: if (cnt == SOFT_END) state_nxt = ST_SOFT;
            ST_SOFT: if (cnt == POR_END)  state_nxt = ST_POR;
            ST_POR:  if (cnt == FULL_END) state_nxt = ST_FULL;
            ST_FULL: begin
                if (masked_up && full_released) state_nxt = ST_RUN;
                else if (cnt == STAT_END)       state_nxt = ST_FAIL;
            end
            ST_RUN, ST_FAIL: if (reseq) state_nxt = ST_HOLD;
            default: state_nxt = ST_HOLD;
        endcase

        fail_set = (state == ST_FULL && state_nxt == ST_FAIL) ? (mask & ~stat) : '0;
        lost_set = (state == ST_RUN) ? stat_fall : '0;

        drive_soft  = (state != ST_HOLD);
        drive_por   = (state == ST_POR) || (state == ST_FULL) || (state == ST_RUN) || (state == ST_FAIL);
        drive_full  = (state == ST_FULL) || (state == ST_RUN) || (state == ST_FAIL);
        drive_strap = !drive_full ||
                      ((strap_cnt < STRAP_LEN) && !(STRAP_AT_END && state != ST_FULL));
    end

    always_ff @(posedge clk_sys) begin
        if (!hard_rst_n) begin
            state      <= ST_HOLD;
            cnt        <= '0;
            strap_cnt  <= '0;
            mask       <= '1;
            seq_ack    <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            fail_vec   <= '0;
            lost_vec   <= '0;
            rst_soft_n <= '0;
            rst_por_n  <= '0;
            rst_full_n <= '0;
            strap_oe   <= '1;
        end else begin
            state     <= state_nxt;
            cnt       <= (state_nxt != state) ? '0 : cnt_inc;
            // Strap hold is timed from FULL entry and keeps running into RUN.
            strap_cnt <= (state_nxt == ST_FULL && state != ST_FULL) ? '0 : strap_inc;
            if (reseq) mask <= reseq_mask;
            seq_ack  <= accept;
            busy     <= !(state == ST_RUN || state == ST_FAIL);
            done     <= (state == ST_RUN) && (&stat);
            fail_vec <= (fail_vec & ~clr_mask) | fail_set;
            lost_vec <= (lost_vec & ~clr_mask) | lost_set;
            for (int i = 0; i < N_DSP; i++) begin
                if (mask[i]) begin
                    rst_soft_n[i] <= drive_soft;
                    rst_por_n[i]  <= drive_por;
                    rst_full_n[i] <= drive_full;
                    strap_oe[i]   <= drive_strap;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsp_rst_seq.sv
// Directed-random bench for dsp_rst_seq against a timeline model of the reset phases.
module tb_dsp_rst_seq;

    localparam int N_DSP  = 2;
    localparam int TS     = 10;
    localparam int TP     = 5;
    localparam int TF     = 4;
    localparam int TSTRAP = 3;
    localparam int TSTAT  = 20;
    localparam int FULL_T = TS + TP + TF;

    logic             clk_sys = 1'b0;
    logic             hard_rst_n;
    logic [N_DSP-1:0] dsp_state;
    logic             seq_req;
    logic [N_DSP-1:0] seq_mask;
    logic             seq_ack;
    logic [N_DSP-1:0] rst_soft_n;
    logic [N_DSP-1:0] rst_por_n;
    logic [N_DSP-1:0] rst_full_n;
    logic [N_DSP-1:0] strap_oe;
    logic             busy;
    logic             done;
    logic [N_DSP-1:0] fail_vec;
    logic [N_DSP-1:0] lost_vec;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    dsp_rst_seq #(
        .N_DSP(N_DSP), .CNT_W(20), .T_SOFT(TS), .T_POR(TP), .T_FULL(TF),
        .T_STRAP(TSTRAP), .T_STAT(TSTAT), .MAX_RETRY(2)
    ) dut (
        .clk_sys        (clk_sys),
        .hard_rst_n     (hard_rst_n),
        .dsp_rstn_state (dsp_state),
        .seq_req        (seq_req),
        .seq_mask       (seq_mask),
        .seq_ack        (seq_ack),
        .rst_soft_n     (rst_soft_n),
        .rst_por_n      (rst_por_n),
        .rst_full_n     (rst_full_n),
        .strap_oe       (strap_oe),
        .busy           (busy),
        .done           (done),
        .fail_vec       (fail_vec),
        .lost_vec       (lost_vec)
    );

`ifdef DSP_RST_WDOG_EN
    int               soft_falls [N_DSP];
    logic [N_DSP-1:0] soft_seen;
    always @(negedge clk_sys) begin
        for (int i = 0; i < N_DSP; i++)
            if (soft_seen[i] === 1'b1 && rst_soft_n[i] === 1'b0) soft_falls[i]++;
        soft_seen = rst_soft_n;
    end
`endif

    task automatic step();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {soft, por, full, strap} for a channel t edges into its own sequence.
    function automatic logic [3:0] chan_model(input int t);
        chan_model = {t >= TS, t >= TS + TP, t >= FULL_T, t < FULL_T + TSTRAP};
    endfunction

    task automatic chk_chan(input string tag, input int ch, input logic [3:0] exp);
        chk($sformatf("%s_soft%0d", tag, ch),  32'(rst_soft_n[ch]), 32'(exp[3]));
        chk($sformatf("%s_por%0d", tag, ch),   32'(rst_por_n[ch]),  32'(exp[2]));
        chk($sformatf("%s_full%0d", tag, ch),  32'(rst_full_n[ch]), 32'(exp[1]));
        chk($sformatf("%s_strap%0d", tag, ch), 32'(strap_oe[ch]),   32'(exp[0]));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_soft"},  32'(rst_soft_n), 32'(0));
        chk({tag, "_por"},   32'(rst_por_n),  32'(0));
        chk({tag, "_full"},  32'(rst_full_n), 32'(0));
        chk({tag, "_strap"}, 32'(strap_oe),   32'(3));
        chk({tag, "_busy"},  32'(busy),       32'(1));
        chk({tag, "_done"},  32'(done),       32'(0));
        chk({tag, "_ack"},   32'(seq_ack),    32'(0));
        chk({tag, "_fail"},  32'(fail_vec),   32'(0));
        chk({tag, "_lost"},  32'(lost_vec),   32'(0));
    endtask

    task automatic do_reset(input string tag);
        hard_rst_n = 1'b0;
        seq_req    = 1'b0;
        repeat (3) step();
        check_reset_vals(tag);
    endtask

    initial begin
        int m;
        int c;
        int f;
        int falls0;
        logic [N_DSP-1:0] one_hot;

        hard_rst_n = 1'b0;
        dsp_state  = '0;
        seq_req    = 1'b0;
        seq_mask   = '0;
        falls0     = 0;

        // Reset with random activity on every input
        repeat (4) begin
            dsp_state = N_DSP'($urandom);
            seq_req   = 1'($urandom);
            seq_mask  = N_DSP'($urandom);
            step();
        end
        check_reset_vals("rst");
        seq_req   = 1'b0;
        dsp_state = '1;
        step();

        // Power-up with random requests during the sequence; all must be ignored
        hard_rst_n = 1'b1;
        for (int t = 0; t <= 30; t++) begin
            seq_req  = (t <= 19) ? 1'($urandom) : 1'b0;
            if (t == 12) seq_req = 1'b1;
            seq_mask = N_DSP'($urandom_range(1, 3));
            step();
            chk_chan("pwr", 0, chan_model(t));
            chk_chan("pwr", 1, chan_model(t));
            chk("pwr_done", 32'(done), 32'(t >= FULL_T + 2));
            chk("pwr_busy", 32'(busy), 32'(t < FULL_T + 2));
            chk("pwr_ack",  32'(seq_ack), 32'(0));
        end

        // Masked re-sequence from RUN
        m = $urandom_range(1, 3);
        seq_req  = 1'b1;
        seq_mask = N_DSP'(m);
        step();
        seq_req = 1'b0;
        chk("rsq_ack", 32'(seq_ack), 32'(1));
        chk_chan("rsq0", 0, 4'b1110);
        chk_chan("rsq0", 1, 4'b1110);
        chk("rsq0_done", 32'(done), 32'(1));
        for (int r = 1; r <= 30; r++) begin
            seq_mask = N_DSP'($urandom);
            step();
            chk("rsq_ack_clr", 32'(seq_ack), 32'(0));
            for (int ch = 0; ch < N_DSP; ch++)
                chk_chan("rsq", ch, m[ch] ? chan_model(r - 1) : 4'b1110);
            chk("rsq_done", 32'(done), 32'((r - 1) >= FULL_T + 2));
            chk("rsq_busy", 32'(busy), 32'((r - 1) < FULL_T + 2));
        end
        chk("rsq_fail", 32'(fail_vec), 32'(0));
        chk("rsq_lost", 32'(lost_vec), 32'(0));

        // RESETSTATn loss while running
        c = $urandom_range(0, 1);
        one_hot = N_DSP'(1 << c);
        dsp_state[c] = 1'b0;
        step();
        chk("lost_e1", 32'(lost_vec), 32'(0));
        step();
        chk("lost_e2", 32'(lost_vec), 32'(0));
        chk("lost_e2_done", 32'(done), 32'(1));
        step();
        chk("lost_e3", 32'(lost_vec), 32'(one_hot));
        chk("lost_e3_done", 32'(done), 32'(0));
`ifdef DSP_RST_WDOG_EN
        falls0 = soft_falls[c];
        repeat (150) step();
        chk("wd_retries", 32'(soft_falls[c] - falls0), 32'(2));
        chk("wd_fail", 32'(fail_vec), 32'(one_hot));
        chk("wd_lost", 32'(lost_vec), 32'(0));
        chk("wd_busy", 32'(busy), 32'(0));
`else
        repeat (20) step();
        chk("lost_hold", 32'(lost_vec), 32'(one_hot));
        chk("lost_hold_done", 32'(done), 32'(0));
        chk("lost_hold_busy", 32'(busy), 32'(0));
        chk("lost_hold_soft", 32'(rst_soft_n), 32'(3));
`endif
        dsp_state = '1;
        seq_req   = 1'b1;
        seq_mask  = one_hot;
        step();
        seq_req = 1'b0;
        chk("rcv_ack", 32'(seq_ack), 32'(1));
        chk("rcv_lost", 32'(lost_vec), 32'(0));
        chk("rcv_fail", 32'(fail_vec), 32'(0));
        for (int k = 0; k < 60 && !done; k++) step();
        chk("rcv_done", 32'(done), 32'(1));

        // One channel never reports RESETSTATn high
        do_reset("rst2");
        f = $urandom_range(0, 1);
        one_hot   = N_DSP'(1 << f);
        dsp_state = ~one_hot;
        hard_rst_n = 1'b1;
        for (int t = 0; t <= 45; t++) begin
            step();
            if (t == 37) begin
                chk("stat_pre_fail", 32'(fail_vec), 32'(0));
                chk("stat_pre_busy", 32'(busy), 32'(1));
            end
            if (t == 38) chk("stat_fail", 32'(fail_vec), 32'(one_hot));
`ifndef DSP_RST_WDOG_EN
            if (t == 45) begin
                chk("stat_busy", 32'(busy), 32'(0));
                chk("stat_done", 32'(done), 32'(0));
                chk("stat_soft", 32'(rst_soft_n), 32'(3));
                chk("stat_por",  32'(rst_por_n),  32'(3));
                chk("stat_full", 32'(rst_full_n), 32'(3));
                chk("stat_fail_hold", 32'(fail_vec), 32'(one_hot));
            end
`endif
        end

        // Hard reset in the middle of POR
        do_reset("rst3");
        dsp_state  = '1;
        hard_rst_n = 1'b1;
        for (int t = 0; t <= 16; t++) step();
        chk("mid_por", 32'(rst_por_n), 32'(3));
        chk("mid_full", 32'(rst_full_n), 32'(0));
        hard_rst_n = 1'b0;
        step();
        check_reset_vals("abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
